// File: rtl/iob_cache_fe_arbiter.sv
// Purpose : shares one cache front-end port among N_MASTERS native-interface requesters.
// Latency : one cycle of arbitration in IDLE, then the request is passed through until s_ready.
// Backpres: the owner sees s_ready as m_ready; all other requesters wait with m_ready low.
//
// Ports:
//   clk, reset            - rising-edge clock, asynchronous active-low reset
//   m_valid/addr/wdata/wstrb - packed per-requester requests (requester i at slice i)
//   m_rdata, m_ready      - s_rdata replicated to every slice, per-requester completion
//   s_valid/addr/wdata/wstrb, s_rdata, s_ready - cache front-end side
//   grant, busy           - current owner index, high while a transaction is open
// Build option: define IOB_CACHE_ARB_FIXED_PRIO_EN for fixed priority (requester 0
// highest, no rotation pointer). Default build is round-robin.
module iob_cache_fe_arbiter #(
  parameter int N_MASTERS  = 2,
  parameter int FE_ADDR_W  = 32,
  parameter int FE_DATA_W  = 32,
  parameter int CTRL_CACHE = 0,
  localparam int FE_NBYTES = FE_DATA_W / 8,
  localparam int AW        = CTRL_CACHE + FE_ADDR_W,
  localparam int GW        = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_MASTERS-1:0]            m_valid,
  input  logic [N_MASTERS*AW-1:0]         m_addr,
  input  logic [N_MASTERS*FE_DATA_W-1:0]  m_wdata,
  input  logic [N_MASTERS*FE_NBYTES-1:0]  m_wstrb,
  output logic [N_MASTERS*FE_DATA_W-1:0]  m_rdata,
  output logic [N_MASTERS-1:0]            m_ready,
  output logic                            s_valid,
  output logic [AW-1:0]                   s_addr,
  output logic [FE_DATA_W-1:0]            s_wdata,
  output logic [FE_NBYTES-1:0]            s_wstrb,
  input  logic [FE_DATA_W-1:0]            s_rdata,
  input  logic                            s_ready,
  output logic [GW-1:0]                   grant,
  output logic                            busy
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        r_state;
  logic [GW-1:0] r_grant;
  logic          r_busy;
  logic [GW-1:0] w_winner;
  logic          w_any;

`ifdef IOB_CACHE_ARB_FIXED_PRIO_EN
  // Lowest asserted index wins; scanning downward leaves the lowest one last.
  always_comb begin
    w_winner = '0;
    w_any    = 1'b0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (m_valid[i]) begin
        w_winner = GW'(i);
        w_any    = 1'b1;
      end
    end
  end
`else
  logic [GW-1:0]            r_ptr;
  // Two copies of m_valid back to back let ptr+k index without a wrap test;
  // 2*N_MASTERS always fits in GW+1 index bits for N_MASTERS in 2..8.
  logic [2*N_MASTERS-1:0]   w_dbl;
  logic [GW:0]              w_pos;
  logic [GW:0]              w_wrap;

  assign w_dbl = {m_valid, m_valid};

  // Scan offsets from far to near so the nearest asserted requester after ptr
  // is the last one written.
  always_comb begin
    w_winner = '0;
    w_any    = 1'b0;
    w_pos    = '0;
    w_wrap   = '0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      w_pos  = {1'b0, r_ptr} + (GW+1)'(k);
      w_wrap = w_pos - (GW+1)'(N_MASTERS);
      if (w_dbl[w_pos]) begin
        w_any    = 1'b1;
        w_winner = (w_pos >= (GW+1)'(N_MASTERS)) ? w_wrap[GW-1:0] : w_pos[GW-1:0];
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_busy  <= 1'b0;
`ifndef IOB_CACHE_ARB_FIXED_PRIO_EN
      r_ptr   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant <= w_winner;
            r_state <= BUSY;
            r_busy  <= 1'b1;
          end
        end
        BUSY: begin
          if (!m_valid[r_grant]) begin
            // Owner withdrew: drop the transaction without moving the pointer.
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (s_ready) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
`ifndef IOB_CACHE_ARB_FIXED_PRIO_EN
            r_ptr   <= (r_grant == GW'(N_MASTERS - 1)) ? '0 : r_grant + GW'(1);
`endif
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Request path muxed from the owner's slice; compare against constant indices
  // so no slice arithmetic depends on the grant value.
  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    m_ready = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (r_grant == GW'(i)) begin
        s_addr     = m_addr[i*AW +: AW];
        s_wdata    = m_wdata[i*FE_DATA_W +: FE_DATA_W];
        s_wstrb    = m_wstrb[i*FE_NBYTES +: FE_NBYTES];
        m_ready[i] = (r_state == BUSY) && s_ready;
      end
    end
  end

  assign s_valid = (r_state == BUSY) && m_valid[r_grant];
  assign m_rdata = {N_MASTERS{s_rdata}};
  assign grant   = r_grant;
  assign busy    = r_busy;

endmodule

// File: tb/tb_iob_cache_fe_arbiter.sv
// Purpose : directed checks of iob_cache_fe_arbiter with 4 and 3 requesters.
// Latency : n/a (testbench).
// Backpres: s_ready is driven by the bench to model cache latency.
module tb_iob_cache_fe_arbiter;

`ifdef IOB_CACHE_ARB_FIXED_PRIO_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // 4-requester instance
  logic [3:0]   mv4 = '0;
  logic [127:0] addr4, wdata4;
  logic [15:0]  wstrb4;
  logic [127:0] rdata4;
  logic [3:0]   mrdy4;
  logic         sv4;
  logic [31:0]  sa4, swd4;
  logic [3:0]   sws4;
  logic [31:0]  srd4 = '0;
  logic         srdy4 = 1'b0;
  logic [1:0]   g4;
  logic         b4;

  // 3-requester instance
  logic [2:0]   mv3 = '0;
  logic [95:0]  addr3, wdata3, rdata3;
  logic [11:0]  wstrb3;
  logic [2:0]   mrdy3;
  logic         sv3;
  logic [31:0]  sa3, swd3;
  logic [3:0]   sws3;
  logic [31:0]  srd3 = 32'h1234_5678;
  logic         srdy3 = 1'b0;
  logic [1:0]   g3;
  logic         b3;

  iob_cache_fe_arbiter #(.N_MASTERS(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .m_valid(mv4), .m_addr(addr4), .m_wdata(wdata4), .m_wstrb(wstrb4),
    .m_rdata(rdata4), .m_ready(mrdy4),
    .s_valid(sv4), .s_addr(sa4), .s_wdata(swd4), .s_wstrb(sws4),
    .s_rdata(srd4), .s_ready(srdy4), .grant(g4), .busy(b4));

  iob_cache_fe_arbiter #(.N_MASTERS(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .m_valid(mv3), .m_addr(addr3), .m_wdata(wdata3), .m_wstrb(wstrb3),
    .m_rdata(rdata3), .m_ready(mrdy3),
    .s_valid(sv3), .s_addr(sa3), .s_wdata(swd3), .s_wstrb(sws3),
    .s_rdata(srd3), .s_ready(srdy3), .grant(g3), .busy(b3));

  // Requester i: address i*0x100, data CAFE000i, strobe from table.
  logic [3:0] strb_tab [4] = '{4'h0, 4'h0, 4'h3, 4'hF};

  function automatic logic [31:0] exp_addr(input logic [1:0] g);
    return 32'(g) * 32'h100;
  endfunction
  function automatic logic [31:0] exp_wdata(input logic [1:0] g);
    return 32'hCAFE_0000 | 32'(g);
  endfunction

  int    n_cmp = 0;
  int    n_err = 0;
  string ctx = "reset";

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", ctx, nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on the 4-requester instance, entered in IDLE.
  task automatic tx4(input logic [3:0] mv, input int lat, input logic [1:0] g);
    logic [31:0] rd;
    mv4 = mv;
    #1;
    chk("idle_svalid", 64'(sv4), 64'd0);
    chk("idle_mready", 64'(mrdy4), 64'd0);
    tick();
    chk("busy", 64'(b4), 64'd1);
    chk("grant", 64'(g4), 64'(g));
    chk("s_valid", 64'(sv4), 64'd1);
    chk("s_addr", 64'(sa4), 64'(exp_addr(g)));
    chk("s_wdata", 64'(swd4), 64'(exp_wdata(g)));
    chk("s_wstrb", 64'(sws4), 64'(strb_tab[g]));
    for (int c = 0; c < lat; c++) begin
      tick();
      chk("wait_mready", 64'(mrdy4), 64'd0);
      chk("wait_grant", 64'(g4), 64'(g));
    end
    rd = $urandom;
    srd4 = rd;
    srdy4 = 1'b1;
    #1;
    chk("m_ready", 64'(mrdy4), 64'(4'b0001 << g));
    chk("m_rdata", 64'(rdata4[32*g +: 32]), 64'(rd));
    tick();
    chk("done_busy", 64'(b4), 64'd0);
    chk("done_mready", 64'(mrdy4), 64'd0);
    srdy4 = 1'b0;
    mv4 = '0;
  endtask

  typedef struct {
    logic [3:0] mv;
    int         lat;
    logic [1:0] g_rr;
    logic [1:0] g_fp;
  } vec_t;

  vec_t tab [9];
  logic [1:0] seq3_rr [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
  logic [1:0] g;

  initial begin
    // Round-robin expectations follow the pointer from 0 after reset.
    tab[0] = '{4'b0010, 3, 2'd1, 2'd1};
    tab[1] = '{4'b0001, 0, 2'd0, 2'd0};
    tab[2] = '{4'b1111, 1, 2'd1, 2'd0};
    tab[3] = '{4'b1011, 0, 2'd3, 2'd0};
    tab[4] = '{4'b1010, 2, 2'd1, 2'd1};
    tab[5] = '{4'b0101, 0, 2'd2, 2'd0};
    tab[6] = '{4'b0111, 0, 2'd0, 2'd0};
    tab[7] = '{4'b1000, 0, 2'd3, 2'd3};
    tab[8] = '{4'b1100, 0, 2'd2, 2'd2};

    for (int i = 0; i < 4; i++) begin
      addr4[32*i +: 32]  = 32'(i) * 32'h100;
      wdata4[32*i +: 32] = 32'hCAFE_0000 | 32'(i);
      wstrb4[4*i +: 4]   = strb_tab[i];
    end
    for (int i = 0; i < 3; i++) begin
      addr3[32*i +: 32]  = 32'h4000 + 32'(i);
      wdata3[32*i +: 32] = 32'(i);
      wstrb3[4*i +: 4]   = 4'h0;
    end

    // Reset state
    #1;
    chk("busy4", 64'(b4), 64'd0);
    chk("grant4", 64'(g4), 64'd0);
    chk("s_valid4", 64'(sv4), 64'd0);
    chk("m_ready4", 64'(mrdy4), 64'd0);
    chk("busy3", 64'(b3), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Table-driven arbitration vectors
    for (int v = 0; v < 9; v++) begin
      ctx = $sformatf("vec%0d", v);
      tx4(tab[v].mv, tab[v].lat, FP ? tab[v].g_fp : tab[v].g_rr);
    end

    // Three requesters all held, s_ready always high: rotation and wrap at 2.
    ctx = "rr3";
    mv3 = 3'b111;
    srdy3 = 1'b1;
    for (int t = 0; t < 4; t++) begin
      g = FP ? 2'd0 : seq3_rr[t];
      tick();
      chk("busy", 64'(b3), 64'd1);
      chk("grant", 64'(g3), 64'(g));
      chk("m_ready", 64'(mrdy3), 64'(3'b001 << g));
      tick();
      chk("idle_busy", 64'(b3), 64'd0);
      chk("idle_mready", 64'(mrdy3), 64'd0);
    end
    mv3 = '0;
    srdy3 = 1'b0;

    // Requester 1 arrives while 0 owns the port.
    ctx = "hold";
    mv4 = 4'b0001;
    tick();
    chk("grant0", 64'(g4), 64'd0);
    mv4 = 4'b0011;
    #1;
    chk("s_addr_kept", 64'(sa4), 64'(exp_addr(2'd0)));
    tick();
    chk("grant_kept", 64'(g4), 64'd0);
    chk("s_addr_kept2", 64'(sa4), 64'(exp_addr(2'd0)));
    chk("mready_none", 64'(mrdy4), 64'd0);
    srdy4 = 1'b1;
    #1;
    chk("mready0", 64'(mrdy4), 64'd1);
    tick();
    srdy4 = 1'b0;
    mv4 = 4'b0010;
    chk("idle_gap", 64'(b4), 64'd0);
    tick();
    chk("grant1", 64'(g4), 64'd1);
    chk("s_addr1", 64'(sa4), 64'(exp_addr(2'd1)));
    srdy4 = 1'b1;
    tick();
    srdy4 = 1'b0;
    mv4 = '0;

    // Owner withdraws: no ready, pointer must stay where it was.
    ctx = "withdraw";
    mv4 = 4'b0100;
    tick();
    chk("grant2", 64'(g4), 64'd2);
    mv4 = 4'b0000;
    srdy4 = 1'b0;
    #1;
    chk("s_valid_drop", 64'(sv4), 64'd0);
    chk("no_ready", 64'(mrdy4), 64'd0);
    tick();
    chk("idle", 64'(b4), 64'd0);
    chk("no_ready2", 64'(mrdy4), 64'd0);
    tx4(4'b1111, 0, FP ? 2'd0 : 2'd2);

    // Asynchronous reset in the middle of a write.
    ctx = "arst";
    mv4 = 4'b1000;
    tick();
    chk("grant3", 64'(g4), 64'd3);
    chk("wstrb", 64'(sws4), 64'hF);
    srdy4 = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("s_valid", 64'(sv4), 64'd0);
    chk("busy", 64'(b4), 64'd0);
    chk("m_ready", 64'(mrdy4), 64'd0);
    chk("grant", 64'(g4), 64'd0);
    @(negedge clk);
    mv4 = '0;
    srdy4 = 1'b0;
    reset = 1'b1;
    #1;
    chk("rel_grant", 64'(g4), 64'd0);
    tick();
    chk("rel_busy", 64'(b4), 64'd0);
    chk("rel_mready", 64'(mrdy4), 64'd0);
    tx4(4'b0010, 0, 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
